// File: rtl/memory_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
// The stage drives request/address/data; the memory answers with a ready strobe.
interface memory_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/memory_stage.sv
// Pipeline MEM stage: issues data-memory accesses, stalls the front of the pipe
// while waiting for mem_ready, aborts after TIMEOUT wait cycles, and feeds MEM/WB.
module memory_stage #(
  parameter int unsigned TIMEOUT = 16   // legal range 2..255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 WB_in,
  input  logic                 MEM_Read_in,
  input  logic                 MEM_Write_in,
  input  logic                 CALL_in,
  input  logic [31:0]          npc_in,
  input  logic [31:0]          ALU_result_in,
  input  logic [31:0]          Reg2_in,
  input  logic [4:0]           R_dest_in,
  memory_stage_if.master       mem,
  output logic                 stall,
  output logic                 WB,
  output logic [31:0]          WB_data,
  output logic [4:0]           R_dest_out,
  output logic                 mem_err
);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [7:0] TIMEOUT_C = TIMEOUT[7:0];

  state_t      r_state;
  state_t      w_state_next;
  logic [7:0]  r_wcnt;
  logic [7:0]  w_wcnt_next;

  logic        r_wb;
  logic [31:0] r_wb_data;
  logic [4:0]  r_rdest;
  logic        r_err;

  logic        w_mem_op;
  logic        w_is_read;
  logic        w_load_result;
  logic        w_abort;
  logic        w_req;
  logic        w_stall;
  logic [31:0] w_result;

  // A simultaneous read+write request is handled as a plain write.
  assign w_mem_op  = MEM_Read_in | MEM_Write_in;
  assign w_is_read = MEM_Read_in & ~MEM_Write_in;
  assign w_result  = w_is_read ? mem.mem_rdata : ALU_result_in;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_wcnt  <= 8'd0;
    end else begin
      r_state <= w_state_next;
      r_wcnt  <= w_wcnt_next;
    end
  end

  // Next-state logic; also decides whether MEM/WB takes a result or a bubble
  always_comb begin
    w_state_next  = r_state;
    w_wcnt_next   = r_wcnt;
    w_load_result = 1'b0;
    w_abort       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (!w_mem_op || mem.mem_ready) begin
          w_load_result = 1'b1;
        end else begin
          w_state_next = WAIT;
          w_wcnt_next  = 8'd1;
        end
      end
      WAIT: begin
        if (mem.mem_ready) begin
          w_state_next  = IDLE;
          w_wcnt_next   = 8'd0;
          w_load_result = 1'b1;
        end else if (r_wcnt >= TIMEOUT_C) begin
          w_state_next = IDLE;
          w_wcnt_next  = 8'd0;
          w_abort      = 1'b1;
        end else begin
          w_wcnt_next = r_wcnt + 8'd1;
        end
      end
      default: begin
        w_state_next = IDLE;
        w_wcnt_next  = 8'd0;
      end
    endcase
  end

  // Output logic; the abort cycle drops stall so upstream moves on
  always_comb begin
    w_req   = 1'b0;
    w_stall = 1'b0;
    if (rst_n) begin
      unique case (r_state)
        IDLE: begin
          w_req   = w_mem_op;
          w_stall = w_mem_op & ~mem.mem_ready;
        end
        WAIT: begin
          w_req   = 1'b1;
          w_stall = ~mem.mem_ready & (r_wcnt < TIMEOUT_C);
        end
        default: begin
          w_req   = 1'b0;
          w_stall = 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_req   = w_req;
  assign mem.mem_we    = w_req & MEM_Write_in;
  assign mem.mem_addr  = w_req ? ALU_result_in : 32'd0;
  assign mem.mem_wdata = w_req ? (CALL_in ? npc_in : Reg2_in) : 32'd0;
  assign stall         = w_stall;

  // MEM/WB pipeline register and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb      <= 1'b0;
      r_wb_data <= 32'd0;
      r_rdest   <= 5'd0;
      r_err     <= 1'b0;
    end else begin
      if (w_load_result) begin
        r_wb      <= WB_in;
        r_wb_data <= w_result;
        r_rdest   <= R_dest_in;
      end else begin
        r_wb      <= 1'b0;
        r_wb_data <= 32'd0;
        r_rdest   <= 5'd0;
      end
      if (w_abort) begin
        r_err <= 1'b1;
      end
    end
  end

  assign WB         = r_wb;
  assign WB_data    = r_wb_data;
  assign R_dest_out = r_rdest;
  assign mem_err    = r_err;

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter: TIMEOUT, 16, maximum WAIT cycles without mem_ready before an access is aborted (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 WB_in, MEM_Read_in, MEM_Write_in, CALL_in  input  1 each  control bits from the EX/MEM buffer.
REQ-005 npc_in  input  32  next-PC from the EX/MEM buffer; ALU_result_in  input  32  address or result; Reg2_in  input  32  store data; R_dest_in  input  5  destination register.
REQ-006 mem_req  output  1  data-memory request; mem_we  output  1  write enable; mem_addr  output  32  address; mem_wdata  output  32  write data.
REQ-007 mem_ready  input  1  memory completion strobe; mem_rdata  input  32  read data, valid when mem_ready=1.
REQ-008 stall  output  1  hold request to the EX/MEM buffer and all earlier stages.
REQ-009 WB  output  1  write-back enable; WB_data  output  32  write-back value; R_dest_out  output  5  destination; all registered (MEM/WB).
REQ-010 mem_err  output  1  sticky timeout flag.

Function
REQ-011 mem_op = MEM_Read_in | MEM_Write_in; with both set, the op SHALL be treated as a write (mem_we=1, no read data used).
REQ-012 FSM states: IDLE, WAIT; 8-bit wait counter wcnt.
REQ-013 mem_req SHALL be combinational: 1 when (IDLE and mem_op) or WAIT; mem_we = MEM_Write_in while mem_req=1, else 0.
REQ-014 mem_addr = ALU_result_in; mem_wdata = CALL_in ? npc_in : Reg2_in; both driven combinationally, 0 when mem_req=0.
REQ-015 IDLE, mem_op=0: stall=0; next edge MEM/WB loads WB_in, ALU_result_in, R_dest_in.
REQ-016 IDLE, mem_op=1, mem_ready=1: zero-wait completion; stall=0; MEM/WB loads WB_in, (read ? mem_rdata : ALU_result_in), R_dest_in; stay IDLE.
REQ-017 IDLE, mem_op=1, mem_ready=0: stall=1 combinationally; next edge -> WAIT, wcnt=1, MEM/WB loads bubble (WB=0, WB_data=0, R_dest_out=0).
REQ-018 WAIT, mem_ready=0, wcnt<TIMEOUT: stall=1; wcnt increments; MEM/WB loads bubble.
REQ-019 WAIT, mem_ready=1: stall=0 in that cycle; next edge MEM/WB loads result per REQ-016, -> IDLE, wcnt=0.
REQ-020 WAIT, mem_ready=0, wcnt=TIMEOUT: abort; stall=0 in that cycle; next edge mem_err<=1, MEM/WB loads bubble, -> IDLE, wcnt=0.
REQ-021 mem_ready in IDLE with mem_op=0 SHALL be ignored.
REQ-022 Each memory op SHALL produce exactly one completed or aborted access; inputs are held stable by the upstream buffer while stall=1.
REQ-023 mem_err SHALL clear only on reset.
REQ-024 Read data SHALL be latched only on the mem_ready cycle; mem_rdata at other times is ignored.

Reset
REQ-025 rst_n=0 SHALL immediately force state=IDLE, wcnt=0, WB=0, WB_data=0, R_dest_out=0, mem_err=0, regardless of clock.
REQ-026 Reset asserted during WAIT SHALL abandon the access; after release, mem_req follows REQ-013 from IDLE.
REQ-027 While rst_n=0, stall SHALL be 0 and mem_req SHALL be 0.

Verification
REQ-028 ALU op: WB_in=1, ALU_result_in=0x1234, R_dest_in=5, no mem op -> next edge WB=1, WB_data=0x1234, R_dest_out=5, stall never 1.
REQ-029 Zero-wait load: MEM_Read_in=1, ALU_result_in=0x100, mem_ready=1, mem_rdata=0xCAFEF00D, R_dest_in=7 -> mem_req=1, mem_we=0, mem_addr=0x100, stall=0; next edge WB_data=0xCAFEF00D, R_dest_out=7.
REQ-030 3-wait store with CALL: MEM_Write_in=1, CALL_in=1, npc_in=0x40, Reg2_in=0x99, mem_ready on 4th cycle -> mem_wdata=0x40, stall=1 for 3 cycles then 0, three bubbles in MEM/WB, single access.
REQ-031 Timeout (TIMEOUT=16): MEM_Read_in=1, mem_ready held 0 -> stall=1 for 16 cycles, 0 on 17th, mem_err=1 after the following edge, WB=0.
REQ-032 Reset mid-WAIT after 2 wait cycles -> all outputs 0 immediately, state IDLE, mem_err=0.
REQ-033 Read+write both set, Reg2_in=0x5 -> mem_we=1, mem_wdata=0x5, WB_data=ALU_result_in on completion.
